// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock
//
// Ports:
//   clock       rising-edge system clock
//   reset       synchronous, active-high
//   start       request a division (taken in IDLE or DONE, ignored in RUN)
//   dividend    numerator, latched on the accepting edge
//   divisor     denominator, latched on the accepting edge
//   busy        high while iterating
//   done        one-cycle pulse, results valid from this cycle on
//   quotient    result quotient
//   remainder   result remainder
//   div_by_zero set with done when the latched divisor was zero
//
// Optional: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count;

    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   partial;
    logic             take;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             q_neg;
    logic             r_neg;
`endif

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign zero_div  = (divisor == '0);
    assign last_iter = (count == CW'(WIDTH - 1));

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Iterate on magnitudes; the most-negative value's magnitude still fits
    // in WIDTH unsigned bits.
    assign a_mag = dividend[WIDTH-1] ? (-dividend) : dividend;
    assign b_mag = divisor[WIDTH-1]  ? (-divisor)  : divisor;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    // The quotient register doubles as the dividend shifter: its MSB is the
    // next dividend bit, and quotient bits enter from the bottom.
    assign partial  = {remainder, quotient[WIDTH-1]};
    assign take     = (partial >= {1'b0, dvs_q});
    // When take is set the true difference is below dvs_q, so WIDTH bits suffice.
    assign rem_step = take ? (partial[WIDTH-1:0] - dvs_q) : partial[WIDTH-1:0];
    assign quo_step = {quotient[WIDTH-2:0], take};

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Sign fix-up folded into the final iteration so latency is unchanged.
    assign quo_fix = q_neg ? (-quo_step) : quo_step;
    assign rem_fix = r_neg ? (-rem_step) : rem_step;
`else
    assign quo_fix = quo_step;
    assign rem_fix = rem_step;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = zero_div ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = zero_div ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; driven only from state flops
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            dvs_q       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else if (accept) begin
            dvs_q       <= b_mag;
            count       <= '0;
            div_by_zero <= zero_div;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg       <= dividend[WIDTH-1];
`endif
            if (zero_div) begin
                // Skips RUN: the final result is loaded directly.
                quotient  <= '1;
                remainder <= dividend;
            end else begin
                quotient  <= a_mag;
                remainder <= '0;
            end
        end else if (state == S_RUN) begin
            count <= count + CW'(1);
            if (last_iter) begin
                quotient  <= quo_fix;
                remainder <= rem_fix;
            end else begin
                quotient  <= quo_step;
                remainder <= rem_step;
            end
        end
    end

endmodule
